// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_ACK
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_t;

    // Wide enough for the largest legal memory latency (15).
    localparam int CNT_W = 4;

    // Counter preload for a given latency: WAIT lasts exactly lat cycles
    // because the terminal-count cycle is the last WAIT cycle.
    function automatic logic [CNT_W-1:0] lat_to_count(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory bus bundle for the unified-memory port arbiter.
// slave: the arbiter side; master: the control/datapath + memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // instruction-fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    // data requester
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    // memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    // status
    logic              busy;
    logic              owner_dm;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_rdata, if_ack,
        output dm_rdata, dm_ack,
        output mem_addr, mem_wdata, mem_wr,
        output busy, owner_dm
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_rdata, if_ack,
        input  dm_rdata, dm_ack,
        input  mem_addr, mem_wdata, mem_wr,
        input  busy, owner_dm
    );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter timing the memory access; zero_o marks terminal count.
module arb_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Load takes precedence; decrement saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between instruction fetch and data
// access. One request is latched per transaction, the bus is held for
// MEM_LAT cycles, then the owner gets read data with a one-cycle ack.
//
// state    | meaning
// ARB_IDLE | no transaction; arbitrate among sampled requests
// ARB_WAIT | memory bus held; counting down MEM_LAT cycles
// ARB_ACK  | owner's ack pulse; read data captured on the edge entering here
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 64,
    parameter int DATA_W        = 64,
    parameter int MEM_LAT       = 2,   // legal 1..15
    parameter int DATA_PRIORITY = 1    // 1: data wins a tie, 0: round-robin
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_to_count(MEM_LAT);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q;
    logic              rr_dm_turn_q;   // 1: data requester wins the next tie
    logic              we_q;
    logic              mem_wr_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic              busy_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic              grant_vld;
    logic              grant_dm;
    logic              wait_done;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    arb_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Grant selection and next-state decode.
    always_comb begin
        state_d   = state_q;
        grant_vld = 1'b0;
        grant_dm  = 1'b0;
        wait_done = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    grant_vld = 1'b1;
                    if (bus.if_req && bus.dm_req) begin
                        grant_dm = (DATA_PRIORITY != 0) ? 1'b1 : rr_dm_turn_q;
                    end else begin
                        grant_dm = bus.dm_req;
                    end
                    cnt_load = 1'b1;
                    state_d  = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (cnt_zero) begin
                    wait_done = 1'b1;
                    state_d   = ARB_ACK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ARB_ACK: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Control: state, one-cycle strobes, ownership and round-robin turn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_IF;
            rr_dm_turn_q <= 1'b0;
            we_q         <= 1'b0;
            mem_wr_q     <= 1'b0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= (state_d != ARB_IDLE);
            mem_wr_q <= 1'b0;
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            if (grant_vld) begin
                owner_q  <= grant_dm ? OWN_DM : OWN_IF;
                we_q     <= grant_dm & bus.dm_we;
                // write strobe covers only the first WAIT cycle
                mem_wr_q <= grant_dm & bus.dm_we;
            end
            if (wait_done) begin
                if (owner_q == OWN_DM) begin
                    dm_ack_q <= 1'b1;
                end else begin
                    if_ack_q <= 1'b1;
                end
            end
            if (state_q == ARB_ACK) begin
                rr_dm_turn_q <= (owner_q == OWN_IF);
            end
        end
    end

    // Data path: latched bus address/data and returned read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if (grant_vld) begin
                mem_addr_q  <= grant_dm ? bus.dm_addr : bus.if_addr;
                mem_wdata_q <= grant_dm ? bus.dm_wdata : '0;
            end
            if (wait_done) begin
                if (owner_q == OWN_IF) begin
                    if_rdata_q <= bus.mem_rdata;
                end else if (!we_q) begin
                    dm_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.busy      = busy_q;
    assign bus.owner_dm  = (owner_q == OWN_DM);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances cover the latency/priority
// configurations; a scoreboard holds expected read data and grant order.
module tb_mem_port_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance 0: LAT 2 data-priority, 1: LAT 2 round-robin, 2: LAT 1, 3: LAT 15
    function automatic int lat_of(input int g);
        return (g == 2) ? 1 : ((g == 3) ? 15 : 2);
    endfunction

    // memory contents: a fixed instruction at 0x10, an address hash elsewhere
    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        if (a == 64'h10) return 64'h0000_0000_0050_0093;
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    logic        if_req_r   [N];
    logic [63:0] if_addr_r  [N];
    logic        dm_req_r   [N];
    logic        dm_we_r    [N];
    logic [63:0] dm_addr_r  [N];
    logic [63:0] dm_wdata_r [N];

    logic        if_ack_w    [N];
    logic        dm_ack_w    [N];
    logic        mem_wr_w    [N];
    logic        busy_w      [N];
    logic        owner_w     [N];
    logic [63:0] if_rdata_w  [N];
    logic [63:0] dm_rdata_w  [N];
    logic [63:0] mem_addr_w  [N];
    logic [63:0] mem_wdata_w [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

        mem_port_arbiter #(
            .ADDR_W        (64),
            .DATA_W        (64),
            .MEM_LAT       (lat_of(g)),
            .DATA_PRIORITY ((g == 1) ? 0 : 1)
        ) u_dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus)
        );

        assign bus.if_req    = if_req_r[g];
        assign bus.if_addr   = if_addr_r[g];
        assign bus.dm_req    = dm_req_r[g];
        assign bus.dm_we     = dm_we_r[g];
        assign bus.dm_addr   = dm_addr_r[g];
        assign bus.dm_wdata  = dm_wdata_r[g];
        assign bus.mem_rdata = mem_fn(bus.mem_addr);

        assign if_ack_w[g]    = bus.if_ack;
        assign dm_ack_w[g]    = bus.dm_ack;
        assign mem_wr_w[g]    = bus.mem_wr;
        assign busy_w[g]      = bus.busy;
        assign owner_w[g]     = bus.owner_dm;
        assign if_rdata_w[g]  = bus.if_rdata;
        assign dm_rdata_w[g]  = bus.dm_rdata;
        assign mem_addr_w[g]  = bus.mem_addr;
        assign mem_wdata_w[g] = bus.mem_wdata;
    end

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] exp_if_q [$];
    logic [63:0] exp_dm_q [$];
    int          own_q    [$];
    logic [63:0] dm_last  [N];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One fetch/load/store from an idle arbiter, with latency and bus checks.
    task automatic run_single(input int g, input bit dm, input bit we,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input string tag);
        int          k;
        int          wr_cnt;
        logic [63:0] wr_addr;
        logic [63:0] wr_data;
        logic        other;
        logic        got;
        logic [63:0] exp;
        k = 0; wr_cnt = 0; wr_addr = '0; wr_data = '0; other = 1'b0; got = 1'b0;
        exp = (dm && we) ? dm_last[g] : mem_fn(addr);
        if (dm) begin
            exp_dm_q.push_back(exp);
            dm_we_r[g] = we; dm_addr_r[g] = addr; dm_wdata_r[g] = wdata; dm_req_r[g] = 1'b1;
        end else begin
            exp_if_q.push_back(exp);
            if_addr_r[g] = addr; if_req_r[g] = 1'b1;
        end
        while (!got && k < 60) begin
            tick();
            k++;
            if (mem_wr_w[g]) begin
                wr_cnt++;
                wr_addr = mem_addr_w[g];
                wr_data = mem_wdata_w[g];
            end
            other = other | (dm ? if_ack_w[g] : dm_ack_w[g]);
            got   = dm ? dm_ack_w[g] : if_ack_w[g];
        end
        chk({tag, "_latency"}, 64'(k), 64'(lat_of(g) + 1));
        chk({tag, "_other_ack"}, 64'(other), 64'd0);
        chk({tag, "_wr_count"}, 64'(wr_cnt), 64'(dm && we));
        if (dm && we) begin
            chk({tag, "_wr_addr"}, wr_addr, addr);
            chk({tag, "_wr_data"}, wr_data, wdata);
        end
        if (dm) begin
            chk({tag, "_dm_rdata"}, dm_rdata_w[g], exp_dm_q.pop_front());
            if (!we) dm_last[g] = exp;
            dm_req_r[g] = 1'b0;
        end else begin
            chk({tag, "_if_rdata"}, if_rdata_w[g], exp_if_q.pop_front());
            if_req_r[g] = 1'b0;
        end
        tick();
        chk({tag, "_ack_pulse"}, 64'(if_ack_w[g] | dm_ack_w[g]), 64'd0);
        chk({tag, "_idle"}, 64'(busy_w[g]), 64'd0);
    endtask

    // Both requesters raise loads in the same cycle; checks grant order and spacing.
    task automatic tie_run(input int g, input int rounds);
        bit dp;
        dp = (g != 1);
        for (int r = 0; r < rounds; r++) begin
            logic [63:0] ia;
            logic [63:0] da;
            int          k;
            int          first;
            int          second;
            int          nack;
            ia = 64'h1000 + 64'(r * 32) + 64'(g * 256);
            da = ia + 64'd8;
            k = 0; first = 0; second = 0; nack = 0;
            own_q.push_back(dp ? 1 : 0);
            own_q.push_back(dp ? 0 : 1);
            exp_if_q.push_back(mem_fn(ia));
            exp_dm_q.push_back(mem_fn(da));
            if_addr_r[g] = ia; if_req_r[g] = 1'b1;
            dm_addr_r[g] = da; dm_we_r[g] = 1'b0; dm_wdata_r[g] = '0; dm_req_r[g] = 1'b1;
            while (nack < 2 && k < 80) begin
                tick();
                k++;
                chk("tie_both_ack", 64'(if_ack_w[g] & dm_ack_w[g]), 64'd0);
                if (if_ack_w[g] || dm_ack_w[g]) begin
                    chk("tie_order", 64'(dm_ack_w[g]), 64'(own_q.pop_front()));
                    if (dm_ack_w[g]) begin
                        chk("tie_dm_rdata", dm_rdata_w[g], exp_dm_q.pop_front());
                        dm_last[g] = mem_fn(da);
                        dm_req_r[g] = 1'b0;
                    end else begin
                        chk("tie_if_rdata", if_rdata_w[g], exp_if_q.pop_front());
                        if_req_r[g] = 1'b0;
                    end
                    if (nack == 0) first = k;
                    else second = k;
                    nack++;
                end
            end
            chk("tie_first_latency", 64'(first), 64'(lat_of(g) + 1));
            chk("tie_gap", 64'(second - first), 64'(lat_of(g) + 2));
            tick();
        end
    endtask

    // Random request streams on the round-robin instance with a live scoreboard.
    task automatic random_run(input int cycles);
        int g;
        int if_age;
        int dm_age;
        bit if_out;
        bit dm_out;
        bit dm_wr_seen;
        g = 1; if_age = 0; dm_age = 0; if_out = 1'b0; dm_out = 1'b0; dm_wr_seen = 1'b0;
        for (int c = 0; c < cycles + 50; c++) begin
            tick();
            if (if_out) if_age++;
            if (dm_out) dm_age++;
            chk("rnd_both_ack", 64'(if_ack_w[g] & dm_ack_w[g]), 64'd0);
            if (busy_w[g]) begin
                chk("rnd_addr_hold", mem_addr_w[g], owner_w[g] ? dm_addr_r[g] : if_addr_r[g]);
            end
            if (mem_wr_w[g]) begin
                chk("rnd_wr_legal", 64'(dm_out & dm_we_r[g] & ~dm_wr_seen & owner_w[g]), 64'd1);
                chk("rnd_wr_addr", mem_addr_w[g], dm_addr_r[g]);
                chk("rnd_wr_data", mem_wdata_w[g], dm_wdata_r[g]);
                dm_wr_seen = 1'b1;
            end
            if (if_ack_w[g]) begin
                chk("rnd_if_pending", 64'(exp_if_q.size()), 64'd1);
                if (exp_if_q.size() > 0) chk("rnd_if_rdata", if_rdata_w[g], exp_if_q.pop_front());
                chk("rnd_if_wait_ok", 64'(if_age <= 9), 64'd1);
                if_out = 1'b0;
                if_req_r[g] = 1'b0;
            end
            if (dm_ack_w[g]) begin
                chk("rnd_dm_pending", 64'(exp_dm_q.size()), 64'd1);
                if (exp_dm_q.size() > 0) chk("rnd_dm_rdata", dm_rdata_w[g], exp_dm_q.pop_front());
                if (dm_we_r[g]) chk("rnd_dm_wr_once", 64'(dm_wr_seen), 64'd1);
                else dm_last[g] = mem_fn(dm_addr_r[g]);
                chk("rnd_dm_wait_ok", 64'(dm_age <= 9), 64'd1);
                dm_out = 1'b0;
                dm_req_r[g] = 1'b0;
            end
            if (c < cycles) begin
                if (!if_out && $urandom_range(0, 2) == 0) begin
                    if_addr_r[g] = {$urandom, $urandom};
                    if_req_r[g]  = 1'b1;
                    exp_if_q.push_back(mem_fn(if_addr_r[g]));
                    if_out = 1'b1;
                    if_age = 0;
                end
                if (!dm_out && $urandom_range(0, 2) == 0) begin
                    dm_we_r[g]    = 1'($urandom_range(0, 1));
                    dm_addr_r[g]  = {$urandom, $urandom};
                    dm_wdata_r[g] = {$urandom, $urandom};
                    dm_req_r[g]   = 1'b1;
                    exp_dm_q.push_back(dm_we_r[g] ? dm_last[g] : mem_fn(dm_addr_r[g]));
                    dm_out = 1'b1;
                    dm_age = 0;
                    dm_wr_seen = 1'b0;
                end
            end
        end
        chk("rnd_if_lost", 64'(exp_if_q.size()), 64'd0);
        chk("rnd_dm_lost", 64'(exp_dm_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_ack;
        rst = 1'b1;
        for (int g = 0; g < N; g++) begin
            if_req_r[g] = 1'b0; if_addr_r[g] = '0;
            dm_req_r[g] = 1'b0; dm_we_r[g] = 1'b0; dm_addr_r[g] = '0; dm_wdata_r[g] = '0;
            dm_last[g] = '0;
        end
        repeat (3) tick();

        // reset state
        for (int g = 0; g < N; g++) begin
            chk("rst_if_ack",   64'(if_ack_w[g]), 64'd0);
            chk("rst_dm_ack",   64'(dm_ack_w[g]), 64'd0);
            chk("rst_busy",     64'(busy_w[g]),   64'd0);
            chk("rst_owner",    64'(owner_w[g]),  64'd0);
            chk("rst_mem_wr",   64'(mem_wr_w[g]), 64'd0);
            chk("rst_mem_addr", mem_addr_w[g],    64'd0);
            chk("rst_if_rdata", if_rdata_w[g],    64'd0);
            chk("rst_dm_rdata", dm_rdata_w[g],    64'd0);
        end
        rst = 1'b0;
        tick();

        // fetch, store, tie with data priority
        run_single(0, 1'b0, 1'b0, 64'h10, 64'h0, "fetch");
        run_single(0, 1'b1, 1'b1, 64'h80, 64'hDEAD_BEEF, "store");
        chk("store_owner", 64'(owner_w[0]), 64'd1);
        tie_run(0, 1);

        // round-robin ties: grants alternate IF, DM, IF, DM
        tie_run(1, 2);

        // latency extremes
        run_single(2, 1'b1, 1'b0, 64'h100, 64'h0, "lat1_load");
        run_single(3, 1'b1, 1'b0, 64'h100, 64'h0, "lat15_load");

        // reset in the middle of a store
        dm_we_r[0] = 1'b1; dm_addr_r[0] = 64'h200; dm_wdata_r[0] = 64'h1234_5678; dm_req_r[0] = 1'b1;
        tick();
        chk("midrst_pre_wr",   64'(mem_wr_w[0]), 64'd1);
        chk("midrst_pre_busy", 64'(busy_w[0]),   64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy",   64'(busy_w[0]),   64'd0);
        chk("midrst_mem_wr", 64'(mem_wr_w[0]), 64'd0);
        saw_ack = 1'b0;
        repeat (2) begin
            tick();
            saw_ack = saw_ack | if_ack_w[0] | dm_ack_w[0];
        end
        chk("midrst_no_ack",   64'(saw_ack), 64'd0);
        chk("midrst_dm_rdata", dm_rdata_w[0], 64'd0);
        rst = 1'b0;
        for (int g = 0; g < N; g++) dm_last[g] = '0;
        run_single(0, 1'b1, 1'b1, 64'h200, 64'h1234_5678, "reissue_store");

        // random streams
        random_run(10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
